// File: rtl/msx_wait_gen.sv
// Z80 WAIT_n generator for the MSX1 bus: stretches each bus cycle by a per-type
// number of wait T-states, timed by the 3.58 MHz clock-enable pair.
//   state  | meaning
//   S_IDLE | no cycle in progress, watching for a strobe rising edge
//   S_WAIT | wait_n held low, counting falling CPU edges down
//   S_HOLD | waits done (or none needed), waiting for strobes to release
module msx_wait_gen #(
  parameter int M1_WAITS   = 1,
  parameter int MEM_WAITS  = 0,
  parameter int IO_WAITS   = 0,
  parameter int VDP_WAITS  = 2,
  parameter int INTA_WAITS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_3m58_p,
  input  logic        ce_3m58_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic [7:0]  addr,
  input  logic        stat_clr,
  output logic        wait_n,
  output logic        busy,
  output logic [15:0] wait_tstates
);

  if (M1_WAITS < 0 || M1_WAITS > 15 || MEM_WAITS < 0 || MEM_WAITS > 15 ||
      IO_WAITS < 0 || IO_WAITS > 15 || VDP_WAITS < 0 || VDP_WAITS > 15 ||
      INTA_WAITS < 0 || INTA_WAITS > 15) begin : g_param_chk
    $error("msx_wait_gen: wait-state parameters must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t     r_state;
  logic [3:0] r_count;
  logic       r_act_q;

  logic       w_act;
  logic       w_start;
  logic       w_release;
  logic       w_vdp;
  logic       w_inc;
  logic [3:0] w_load;

  assign w_act     = ~mreq_n | ~iorq_n;
  assign w_start   = ce_3m58_p & w_act & ~r_act_q;
  assign w_release = ce_3m58_p & ~w_act;
  assign w_vdp     = (addr == 8'h98) || (addr == 8'h99);
  // An abort on the same clk as a falling edge ends the cycle without counting it.
  assign w_inc     = (r_state == S_WAIT) & ce_3m58_n & ~w_release;

  always_comb begin
    if (~m1_n & ~iorq_n)       w_load = 4'(INTA_WAITS);
    else if (~m1_n & ~mreq_n)  w_load = 4'(M1_WAITS);
    else if (~iorq_n & w_vdp)  w_load = 4'(VDP_WAITS);
    else if (~iorq_n)          w_load = 4'(IO_WAITS);
    else                       w_load = 4'(MEM_WAITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= 4'd0;
      r_act_q      <= 1'b0;
      wait_n       <= 1'b1;
      busy         <= 1'b0;
      wait_tstates <= 16'd0;
    end else begin
      if (ce_3m58_p) r_act_q <= w_act;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            busy <= 1'b1;
            if (w_load != 4'd0) begin
              r_state <= S_WAIT;
              r_count <= w_load;
              wait_n  <= 1'b0;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            wait_n  <= 1'b1;
            busy    <= 1'b0;
          end else if (ce_3m58_n) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
              r_state <= S_HOLD;
              wait_n  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_release) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 4'd0;
          wait_n  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase

      if (stat_clr)
        wait_tstates <= 16'd0;
      else if (w_inc && wait_tstates != 16'hFFFF)
        wait_tstates <= wait_tstates + 16'd1;
    end
  end

endmodule

// File: tb/tb_msx_wait_gen.sv
// Scoreboard bench for msx_wait_gen: a Z80-like bus master issues cycles, a
// monitor counts wait T-states per cycle; a second fast instance covers saturation.
module tb_msx_wait_gen;

  localparam int M1W = 1, MEMW = 0, IOW = 0, VDPW = 2, INTAW = 3;

  logic clk = 1'b0;
  logic clk_f = 1'b0;
  always #10 clk = ~clk;
  always #1 clk_f = ~clk_f;

  logic        reset, ce_p, ce_n, m1_n, mreq_n, iorq_n, stat_clr;
  logic [7:0]  addr;
  logic        wait_n, busy;
  logic [15:0] wait_tstates;

  logic        s_reset, s_ce_p, s_ce_n, s_m1_n, s_mreq_n, s_iorq_n, s_clr;
  logic [7:0]  s_addr;
  logic        s_wait_n, s_busy;
  logic [15:0] s_wt;

  msx_wait_gen #(.M1_WAITS(M1W), .MEM_WAITS(MEMW), .IO_WAITS(IOW),
                 .VDP_WAITS(VDPW), .INTA_WAITS(INTAW)) dut (
    .clk(clk), .reset(reset), .ce_3m58_p(ce_p), .ce_3m58_n(ce_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .addr(addr),
    .stat_clr(stat_clr), .wait_n(wait_n), .busy(busy), .wait_tstates(wait_tstates)
  );

  msx_wait_gen #(.M1_WAITS(15)) dut_sat (
    .clk(clk_f), .reset(s_reset), .ce_3m58_p(s_ce_p), .ce_3m58_n(s_ce_n),
    .m1_n(s_m1_n), .mreq_n(s_mreq_n), .iorq_n(s_iorq_n), .addr(s_addr),
    .stat_clr(s_clr), .wait_n(s_wait_n), .busy(s_busy), .wait_tstates(s_wt)
  );

  typedef struct {int waits; int stats;} exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_stats = 0;
  bit   mon_en = 0;
  bit   sat_done = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Wait T-states the bus rules call for, by cycle kind: 0=M1, 1=mem, 2=I/O, 3=INTA.
  function automatic int exp_waits(input int kind, input logic [7:0] a);
    case (kind)
      0: return M1W;
      1: return MEMW;
      2: return (a == 8'h98 || a == 8'h99) ? VDPW : IOW;
      default: return INTAW;
    endcase
  endfunction

  task automatic tick(input bit p, input bit n);
    @(negedge clk);
    ce_p = p;
    ce_n = n;
  endtask

  task automatic t_rest(output bit w);
    tick(0, 0);
    tick(0, 1);
    w = !wait_n;
    tick(0, 0);
  endtask

  task automatic t_state(output bit w);
    tick(1, 0);
    t_rest(w);
  endtask

  task automatic bus_cycle(input int kind, input logic [7:0] a);
    int tb_len, t, guard, n;
    bit w;
    n = exp_waits(kind, a);
    model_stats = (model_stats + n > 65535) ? 65535 : model_stats + n;
    exp_q.push_back('{n, model_stats});
    tb_len = (kind == 1) ? 3 : (kind == 3) ? 5 : 4;
    @(negedge clk);
    ce_p = 1; ce_n = 0; addr = a;
    m1_n   = !(kind == 0 || kind == 3);
    mreq_n = !(kind <= 1);
    iorq_n = !(kind >= 2);
    t_rest(w);
    t = w ? 0 : 1;
    guard = 0;
    while (t < tb_len && guard < 40) begin
      t_state(w);
      if (!w) t++;
      guard++;
    end
    if (guard >= 40) begin
      failures++;
      $display("FAIL cycle_bound: kind %0d still waiting after %0d T-states", kind, guard);
    end
    @(negedge clk);
    ce_p = 1; ce_n = 0; m1_n = 1; mreq_n = 1; iorq_n = 1;
    t_rest(w);
    t_state(w);
  endtask

  initial begin : monitor
    bit prev_busy;
    int low_cnt;
    exp_t e;
    prev_busy = 0;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en || reset) begin
        prev_busy = 0;
        low_cnt = 0;
      end else begin
        if (ce_n && !wait_n) low_cnt++;
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: busy fell with %0d waits, no cycle pending", low_cnt);
          end else begin
            e = exp_q.pop_front();
            check("sb_waits", low_cnt, e.waits);
            check("sb_wait_tstates", int'(wait_tstates), e.stats);
          end
          low_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    bit w;
    int kind, guard;
    logic [7:0] io_tab [6];
    io_tab = '{8'h98, 8'h99, 8'h97, 8'h9A, 8'hA0, 8'h00};
    reset = 1; ce_p = 0; ce_n = 0; m1_n = 1; mreq_n = 1; iorq_n = 1;
    addr = 8'h00; stat_clr = 0;
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (25) t_state(w);
    check("reset_wait_n", wait_n, 1);
    check("reset_busy", busy, 0);
    check("reset_wait_tstates", int'(wait_tstates), 0);

    mon_en = 1;
    bus_cycle(0, 8'h00);
    bus_cycle(2, 8'h98);
    bus_cycle(2, 8'hA0);
    bus_cycle(3, 8'hFF);
    bus_cycle(1, 8'h12);
    bus_cycle(2, 8'h99);
    bus_cycle(2, 8'h9A);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      io_tab[5] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        ce_p = 0; ce_n = 0; stat_clr = 1;
        @(negedge clk);
        stat_clr = 0;
        model_stats = 0;
      end
      bus_cycle(kind, (kind == 2) ? io_tab[$urandom_range(0, 5)] : 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) t_state(w);
    end

    t_state(w);
    mon_en = 0;
    check("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    ce_p = 1; ce_n = 0; iorq_n = 0; addr = 8'h98;
    tick(0, 0);
    check("pre_reset_wait_n", wait_n, 0);
    check("pre_reset_busy", busy, 1);
    reset = 1; iorq_n = 1;
    @(negedge clk);
    check("mid_reset_wait_n", wait_n, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_wait_tstates", int'(wait_tstates), 0);
    reset = 0;
    model_stats = 0;
    exp_q.delete();
    t_state(w);
    mon_en = 1;
    bus_cycle(0, 8'h40);
    bus_cycle(2, 8'h98);
    t_state(w);
    check("sb_empty", exp_q.size(), 0);

    guard = 0;
    while (!sat_done && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!sat_done) begin
      failures++;
      $display("FAIL sat_timeout: saturation sequence not finished after %0d clk", guard);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Fast instance: both enables every clk, 15-wait fetches to reach 0xFFFF quickly.
  initial begin : sat_proc
    s_reset = 1; s_ce_p = 0; s_ce_n = 0; s_m1_n = 1; s_mreq_n = 1;
    s_iorq_n = 1; s_addr = 8'h00; s_clr = 0;
    repeat (3) @(negedge clk_f);
    s_reset = 0; s_ce_p = 1; s_ce_n = 1;
    for (int c = 0; c < 4370; c++) begin
      @(negedge clk_f);
      if (c == 4368) check("sat_progress", int'(s_wt), 65520);
      if (c == 4369) check("sat_reach", int'(s_wt), 65535);
      s_m1_n = 0; s_mreq_n = 0;
      repeat (16) @(negedge clk_f);
      s_m1_n = 1; s_mreq_n = 1;
    end
    @(negedge clk_f);
    check("sat_hold", int'(s_wt), 65535);
    check("sat_busy_idle", s_busy, 0);

    s_m1_n = 0; s_mreq_n = 0;
    repeat (3) @(negedge clk_f);
    s_clr = 1;
    @(negedge clk_f);
    s_clr = 0;
    check("clr_wins", int'(s_wt), 0);
    repeat (12) @(negedge clk_f);
    s_m1_n = 1; s_mreq_n = 1;
    @(negedge clk_f);
    check("after_clr_count", int'(s_wt), 12);

    s_m1_n = 0; s_mreq_n = 0;
    repeat (2) @(negedge clk_f);
    check("abort_pre_wait_n", s_wait_n, 0);
    check("abort_pre_busy", s_busy, 1);
    s_m1_n = 1; s_mreq_n = 1; s_ce_n = 0;
    @(negedge clk_f);
    check("abort_wait_n", s_wait_n, 1);
    check("abort_busy", s_busy, 0);
    check("abort_count", int'(s_wt), 13);
    s_ce_n = 1;
    s_m1_n = 0; s_mreq_n = 0;
    repeat (16) @(negedge clk_f);
    s_m1_n = 1; s_mreq_n = 1;
    @(negedge clk_f);
    check("post_abort_count", int'(s_wt), 28);
    check("post_abort_wait_n", s_wait_n, 1);
    sat_done = 1;
  end

endmodule
